bar_height_packer: RTL
======================

# bar_height_packer

Hardware writer for the bar-height FIFO that feeds the VGA renderer. Accepts a stream of 20 spectrum magnitudes per frame and scales each to a 6-bit bar height. Packs four heights per 32-bit word, writes five words per frame into the single-clock VGA FIFO, then pulses a frame-ready strobe. That strobe starts the existing five-word read-and-unpack sequence. Replaces the software path that drove the FIFO data/wrreq PIOs and the data_back PIO.

## Interface
Parameters:
- MAG_W, 16, width of input magnitude
- SHIFT, 6, right-shift applied to magnitude before saturation
- BARS, 20, bars per frame; fixed at 20, other values unsupported

Ports:
- CLOCK_50  in  1  sole clock; one clock; all logic on its rising edge
- reset_n  in  1  reset is asynchronous and active-low
- bar_valid  in  1  bar_mag/bar_first valid this cycle
- bar_first  in  1  marks bar 0 of a frame; qualified by bar_valid
- bar_mag  in  MAG_W  unsigned magnitude
- bar_ready  out  1  block can accept a bar this cycle
- fifo_full  in  1  VGA FIFO full flag
- fifo_wrreq  out  1  FIFO write request, registered
- fifo_data  out  32  FIFO write data, registered
- frame_ready  out  1  one-cycle pulse: all 5 words of a frame written; drives data_back
- sync_err  out  1  one-cycle pulse: frame restarted by bar_first mid-frame

## Operation
- Height: h = (bar_mag >> SHIFT); height = (h > 63) ? 6'd63 : h[5:0].
- Lane mapping: bar 4k+j goes to word k, bits [8j+5:8j]; bits [8j+7:8j+6] always 0.
- Counters: lane 0..3, word 0..4; both 0 after reset.
- Accept: bar_valid && bar_ready.
  - bar_first=0: the height is stored in lane `lane` of the assembly register, and lane increments.
  - bar_first=1: the height is stored as lane 0, lane becomes 1, and word becomes 0.
- Accepting lane 3 copies the assembly word to the pending register, sets pending=1, and clears the assembly register.
- bar_ready = !pending (combinational from register).
- Write: the block writes on a cycle with pending && !fifo_full. Next edge:
  - fifo_wrreq<=1, fifo_data<=pending word, pending<=0;
  - if word==4: word<=0 and frame_ready<=1, else word<=word+1.
  - On all other cycles fifo_wrreq<=0 and frame_ready<=0; fifo_data holds its value.
- Since frame_ready and the fifth wrreq are registered on the same edge, the fifth word is in the FIFO when the reader sees frame_ready on the following edge.
- Bars before the first bar_first after reset are accepted but written normally; the frame boundary is defined by the word count.
- Resync: bar_first accepted with lane!=0 or word!=0 (partial frame):
  - partial assembly is discarded and sync_err pulses 1 cycle;
  - words already in the FIFO are not recalled, and the reader relies on frame_ready only.
- Pending word: while pending=1, bar_ready=0, so bar_first cannot arrive and the pending word is always written.

## Timing
- Reset values: bar_ready=1, fifo_wrreq=0, fifo_data=32'h0, frame_ready=0, sync_err=0, counters 0, pending=0.
- Reset asserted mid-frame discards everything at once.
- Latency, when the FIFO is not full: fourth bar accepted at edge N; fifo_wrreq high in cycle N+1..N+2 (edge N+1 registers it).
- bar_ready is low for exactly 1 cycle per word when the FIFO is not full. Sustained throughput is 4 bars per 5 cycles.
- fifo_full held high: pending is held, fifo_wrreq=0, bar_ready=0, and no data is lost. The write occurs on the first edge sampling fifo_full=0.
- fifo_wrreq is never asserted on an edge where fifo_full was sampled 1.
- frame_ready is exactly 1 cycle wide, once per 5 words.
- sync_err and frame_ready never coincide.

## Test plan
- Reset, then 20 bars with bar_mag=(i+1)<<6, bar_first on i=0, fifo_full=0. Required:
  - 5 wrreq pulses: 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211;
  - one frame_ready pulse on the edge of the fifth wrreq.
- Saturation: bar_mag=16'hFFFF for all bars -> every word 32'h3F3F3F3F, and bits 7:6 of each byte are 0.
- Backpressure: hold fifo_full=1 for 10 cycles after the 4th bar. Required:
  - bar_ready=0 and fifo_wrreq=0 throughout;
  - one wrreq of 32'h04030201 on the edge after fifo_full falls;
  - no duplicate write.
- Resync: 6 bars, then bar_first with mag 9<<6, then 19 more bars with mags 10..28 <<6. Required:
  - sync_err pulses once;
  - the first word 32'h04030201 was already written, then the next word is 32'h0C0B0A09;
  - frame_ready after 5 words of the new frame.
- Reset mid-frame: assert reset_n=0 after bar 10. Required:
  - all outputs return to reset values immediately;
  - the next full 20-bar frame yields exactly 5 words and 1 frame_ready.
- Back-to-back frames with bar_valid=1 continuously and full FIFO never asserted. Required:
  - 10 words, 2 frame_ready pulses, bar_ready duty 4/5.

Source files
------------

// File: rtl/bar_height_packer.sv
// Scales a 20-bar spectrum stream to 6-bit heights, packs four per word and
// writes five words per frame into the VGA FIFO, pulsing frame_ready after the fifth.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_FILL | assembling a word; bars accepted
// ST_PEND | full word waiting for the FIFO; bars refused until written
module bar_height_packer #(
    parameter int MAG_W = 16,
    parameter int SHIFT = 6,
    parameter int BARS  = 20
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             bar_valid,
    input  logic             bar_first,
    input  logic [MAG_W-1:0] bar_mag,
    output logic             bar_ready,
    input  logic             fifo_full,
    output logic             fifo_wrreq,
    output logic [31:0]      fifo_data,
    output logic             frame_ready,
    output logic             sync_err
);

    localparam int         WORDS     = BARS / 4;
    localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       lane;
    logic [2:0]       word;
    logic [31:0]      asm_word;
    logic [31:0]      pend_word;
    logic [MAG_W-1:0] h_shift;
    logic [5:0]       height;
    logic [1:0]       tgt_lane;
    logic [31:0]      merged;
    logic             accept;
    logic             write_en;
    logic             resync;
    logic             lane_done;

    assign h_shift   = bar_mag >> SHIFT;
    assign height    = (h_shift > MAG_W'(63)) ? 6'd63 : h_shift[5:0];
    assign bar_ready = (state == ST_FILL);
    assign accept    = bar_valid && bar_ready;
    assign write_en  = (state == ST_PEND) && !fifo_full;
    assign resync    = accept && bar_first && ((lane != 2'd0) || (word != 3'd0));
    assign lane_done = accept && !bar_first && (lane == 2'd3);

    // bar_first always lands in lane 0 of a fresh word, dropping any partial assembly
    assign tgt_lane = bar_first ? 2'd0 : lane;
    assign merged   = (bar_first ? 32'h0 : asm_word) | (32'(height) << {tgt_lane, 3'b000});

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FILL: if (lane_done) state_nx = ST_PEND;
            ST_PEND: if (!fifo_full) state_nx = ST_FILL;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            lane        <= 2'd0;
            word        <= 3'd0;
            asm_word    <= 32'h0;
            pend_word   <= 32'h0;
            fifo_wrreq  <= 1'b0;
            fifo_data   <= 32'h0;
            frame_ready <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            sync_err    <= resync;
            fifo_wrreq  <= write_en;
            frame_ready <= write_en && (word == LAST_WORD);

            if (accept) begin
                if (bar_first) begin
                    asm_word <= merged;
                    lane     <= 2'd1;
                    word     <= 3'd0;
                end else if (lane == 2'd3) begin
                    pend_word <= merged;
                    asm_word  <= 32'h0;
                    lane      <= 2'd0;
                end else begin
                    asm_word <= merged;
                    lane     <= lane + 2'd1;
                end
            end

            // accept and write are mutually exclusive, so word has a single updater per cycle
            if (write_en) begin
                fifo_data <= pend_word;
                word      <= (word == LAST_WORD) ? 3'd0 : word + 3'd1;
            end
        end
    end

endmodule
